// File: rtl/servo_ramp.sv
// servo_ramp: servo position sequencer feeding a frame-based PWM stage.
// Accepts angle commands over valid/ready and converts each to a pulse width
// in clocks. Slews pos toward that width by at most STEP per frame, and
// updates only on frame boundaries so the PWM stage never sees a mid-frame
// change.
//
// Ports:
//   clk        system clock
//   rstn       synchronous active-low reset
//   enable     request servo drive on
//   cmd_data   commanded angle 0..255
//   cmd_valid  command present
//   cmd_ready  command slot free (transfer on cmd_valid && cmd_ready)
//   pos        pulse width to the PWM stage (0 while off)
//   timer_ena  PWM frame-counter enable
//   frame_tick high on the last cycle of each frame
//   busy       pending command held, or pos still ramping while running
module servo_ramp #(
  parameter int unsigned FRAME   = 240000,
  parameter int unsigned POS_MIN = 12000,
  parameter int unsigned POS_MAX = 24000,
  parameter int unsigned SCALE   = 47,
  parameter int unsigned STEP    = 240
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        enable,
  input  logic [7:0]  cmd_data,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  output logic [17:0] pos,
  output logic        timer_ena,
  output logic        frame_tick,
  output logic        busy
);

  localparam int unsigned PW    = 18;
  localparam int unsigned CW    = 18;
  localparam int unsigned AW    = 8;
  localparam int unsigned PRODW = 14;

  typedef enum logic {S_OFF, S_RUN} state_t;

  // Angle to pulse width, clamped at POS_MAX.
  function automatic logic [PW-1:0] to_width(input logic [AW-1:0] angle);
    logic [PRODW-1:0] prod;
    logic [PW-1:0]    sum;
    prod = PRODW'(32'(angle) * SCALE);
    sum  = PW'(POS_MIN) + PW'(prod);
    if (sum > PW'(POS_MAX)) sum = PW'(POS_MAX);
    return sum;
  endfunction

  // One bounded slew step of cur toward tgt; STEP of 0 jumps straight there.
  function automatic logic [PW-1:0] step_to(input logic [PW-1:0] cur,
                                            input logic [PW-1:0] tgt);
    logic [PW-1:0] res;
    if (STEP == 0) begin
      res = tgt;
    end else if (tgt >= cur) begin
      res = ((tgt - cur) <= PW'(STEP)) ? tgt : cur + PW'(STEP);
    end else begin
      res = ((cur - tgt) <= PW'(STEP)) ? tgt : cur - PW'(STEP);
    end
    return res;
  endfunction

  localparam logic [PW-1:0] DEF_TARGET = to_width(AW'(128));

  state_t        state, state_nx;
  logic [PW-1:0] pend_q, pend_nx;
  logic [PW-1:0] target_q, target_nx;
  logic [PW-1:0] cur_q, cur_nx;
  logic [CW-1:0] cnt_q, cnt_nx;
  logic          ready_nx;
  logic [PW-1:0] pos_nx;
  logic          timer_nx;
  logic          tick_nx;
  logic          busy_nx;
  logic          accept;
  logic          run_nx;

  // State and datapath registers; every output is taken from here.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= S_OFF;
      pend_q     <= '0;
      target_q   <= DEF_TARGET;
      cur_q      <= DEF_TARGET;
      cnt_q      <= '0;
      cmd_ready  <= 1'b1;
      pos        <= '0;
      timer_ena  <= 1'b0;
      frame_tick <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      pend_q     <= pend_nx;
      target_q   <= target_nx;
      cur_q      <= cur_nx;
      cnt_q      <= cnt_nx;
      cmd_ready  <= ready_nx;
      pos        <= pos_nx;
      timer_ena  <= timer_nx;
      frame_tick <= tick_nx;
      busy       <= busy_nx;
    end
  end

  // Next-state, handshake, slew and frame counter.
  // The pending slot is full exactly when cmd_ready is low.
  always_comb begin
    state_nx  = state;
    pend_nx   = pend_q;
    target_nx = target_q;
    cur_nx    = cur_q;
    cnt_nx    = cnt_q;
    ready_nx  = cmd_ready;
    accept    = cmd_valid && cmd_ready;

    case (state)
      S_OFF: begin
        cnt_nx = '0;
        if (!cmd_ready) begin
          target_nx = pend_q;
          ready_nx  = 1'b1;
        end
        // No ramp from zero: drive starts at the (possibly just loaded) target.
        if (enable) begin
          state_nx = S_RUN;
          cur_nx   = target_nx;
        end
      end
      S_RUN: begin
        if (frame_tick) begin
          cnt_nx = '0;
          // Slew uses the target held before this tick.
          cur_nx = step_to(cur_q, target_q);
          if (!cmd_ready) begin
            target_nx = pend_q;
            ready_nx  = 1'b1;
          end
          // Dropping enable only takes effect once the frame has completed.
          if (!enable) state_nx = S_OFF;
        end else begin
          cnt_nx = cnt_q + CW'(1);
        end
      end
      default: state_nx = S_OFF;
    endcase

    // Accept only happens with an empty slot, so it never races a transfer.
    if (accept) begin
      pend_nx  = to_width(cmd_data);
      ready_nx = 1'b0;
    end

    run_nx   = (state_nx == S_RUN);
    timer_nx = run_nx;
    // pos must be 0 while the PWM counter is held, or its output sticks high.
    pos_nx   = run_nx ? cur_nx : '0;
    tick_nx  = run_nx && (cnt_nx == CW'(FRAME - 1));
    busy_nx  = !ready_nx || (run_nx && (cur_nx != target_nx));
  end

endmodule

// File: tb/tb_servo_ramp.sv
// Directed bench for servo_ramp: three instances with short frames.
//   a: STEP=240 (ramp, handshake, enable drop, reset)
//   b: STEP=0   (direct jump)
//   c: STEP=0, POS_MAX=20000 (width clamp)
module tb_servo_ramp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        a_rstn, a_enable, a_cmd_valid, a_cmd_ready, a_timer_ena, a_frame_tick, a_busy;
  logic [7:0]  a_cmd_data;
  logic [17:0] a_pos;
  logic        b_rstn, b_enable, b_cmd_valid, b_cmd_ready, b_timer_ena, b_frame_tick, b_busy;
  logic [7:0]  b_cmd_data;
  logic [17:0] b_pos;
  logic        c_rstn, c_enable, c_cmd_valid, c_cmd_ready, c_timer_ena, c_frame_tick, c_busy;
  logic [7:0]  c_cmd_data;
  logic [17:0] c_pos;

  servo_ramp #(.FRAME(16), .POS_MIN(12000), .POS_MAX(24000), .SCALE(47), .STEP(240)) u_a (
    .clk(clk), .rstn(a_rstn), .enable(a_enable), .cmd_data(a_cmd_data),
    .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready), .pos(a_pos),
    .timer_ena(a_timer_ena), .frame_tick(a_frame_tick), .busy(a_busy));

  servo_ramp #(.FRAME(16), .POS_MIN(12000), .POS_MAX(24000), .SCALE(47), .STEP(0)) u_b (
    .clk(clk), .rstn(b_rstn), .enable(b_enable), .cmd_data(b_cmd_data),
    .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .pos(b_pos),
    .timer_ena(b_timer_ena), .frame_tick(b_frame_tick), .busy(b_busy));

  servo_ramp #(.FRAME(8), .POS_MIN(12000), .POS_MAX(20000), .SCALE(47), .STEP(0)) u_c (
    .clk(clk), .rstn(c_rstn), .enable(c_enable), .cmd_data(c_cmd_data),
    .cmd_valid(c_cmd_valid), .cmd_ready(c_cmd_ready), .pos(c_pos),
    .timer_ena(c_timer_ena), .frame_tick(c_frame_tick), .busy(c_busy));

  // Advance n clock edges, leaving time 1 unit past the last edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int exp_pos;
    int prev_pos;

    a_rstn = 1'b0; a_enable = 1'b0; a_cmd_valid = 1'b0; a_cmd_data = 8'd0;
    b_rstn = 1'b0; b_enable = 1'b0; b_cmd_valid = 1'b0; b_cmd_data = 8'd0;
    c_rstn = 1'b0; c_enable = 1'b0; c_cmd_valid = 1'b0; c_cmd_data = 8'd0;
    cyc(2);
    chk("rst_pos", a_pos, 0);
    chk("rst_timer", a_timer_ena, 0);
    chk("rst_tick", a_frame_tick, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_ready", a_cmd_ready, 1);
    chk("b_rst_pos", b_pos, 0);
    chk("b_rst_ready", b_cmd_ready, 1);
    a_rstn = 1'b1; b_rstn = 1'b1; c_rstn = 1'b1;
    cyc(1);

    // Enable with no command: default target, ticks every 16 cycles.
    a_enable = 1'b1;
    cyc(1);
    chk("en_timer", a_timer_ena, 1);
    chk("en_pos", a_pos, 18016);
    chk("en_busy", a_busy, 0);
    chk("en_tick0", a_frame_tick, 0);
    cyc(14);
    chk("tick_early", a_frame_tick, 0);
    cyc(1);
    chk("tick1", a_frame_tick, 1);
    cyc(1);
    chk("tick1_next", a_frame_tick, 0);
    cyc(15);
    chk("tick2", a_frame_tick, 1);
    cyc(5);

    // Angle 255 accepted mid-frame, transferred at the next tick.
    chk("ramp_ready_pre", a_cmd_ready, 1);
    a_cmd_data = 8'd255; a_cmd_valid = 1'b1;
    cyc(1);
    a_cmd_valid = 1'b0;
    chk("ramp_ready_lo", a_cmd_ready, 0);
    chk("ramp_busy_pend", a_busy, 1);
    chk("ramp_pos_hold", a_pos, 18016);
    cyc(11);
    chk("ramp_xfer_pos", a_pos, 18016);
    chk("ramp_xfer_ready", a_cmd_ready, 1);
    chk("ramp_xfer_busy", a_busy, 1);
    prev_pos = 18016;
    for (int i = 1; i <= 25; i++) begin
      exp_pos = (i < 25) ? 18016 + 240 * i : 23985;
      cyc(15);
      chk("ramp_last_cycle_pos", a_pos, prev_pos);
      chk("ramp_last_cycle_tick", a_frame_tick, 1);
      cyc(1);
      chk("ramp_step_pos", a_pos, exp_pos);
      chk("ramp_step_busy", a_busy, (i < 25) ? 1 : 0);
      prev_pos = exp_pos;
    end

    // Back-to-back commands with cmd_valid held: angle 0, then angle 100.
    a_cmd_data = 8'd0; a_cmd_valid = 1'b1;
    cyc(1);
    chk("b2b_ready_lo", a_cmd_ready, 0);
    a_cmd_data = 8'd100;
    cyc(14);
    chk("b2b_ready_at_tick", a_cmd_ready, 0);
    chk("b2b_tick", a_frame_tick, 1);
    cyc(1);
    chk("b2b_ready_back", a_cmd_ready, 1);
    chk("b2b_pos_top", a_pos, 23985);
    cyc(1);
    a_cmd_valid = 1'b0;
    chk("b2b_second_acc", a_cmd_ready, 0);
    cyc(15);
    chk("b2b_first_step", a_pos, 23745);
    chk("b2b_ready2", a_cmd_ready, 1);
    chk("b2b_busy", a_busy, 1);
    cyc(16 * 29);
    chk("b2b_near", a_pos, 16785);
    chk("b2b_near_busy", a_busy, 1);
    cyc(16);
    chk("b2b_final", a_pos, 16700);
    chk("b2b_final_busy", a_busy, 0);

    // Enable dropped mid-frame: the frame completes, then drive stops.
    cyc(5);
    a_enable = 1'b0;
    cyc(1);
    chk("off_mid_timer", a_timer_ena, 1);
    chk("off_mid_pos", a_pos, 16700);
    cyc(9);
    chk("off_last_timer", a_timer_ena, 1);
    chk("off_last_pos", a_pos, 16700);
    chk("off_last_tick", a_frame_tick, 1);
    cyc(1);
    chk("off_timer", a_timer_ena, 0);
    chk("off_pos", a_pos, 0);
    chk("off_tick", a_frame_tick, 0);
    chk("off_busy", a_busy, 0);
    a_enable = 1'b1;
    cyc(1);
    chk("reen_timer", a_timer_ena, 1);
    chk("reen_pos", a_pos, 16700);

    // Enable drop on the same tick as a pending transfer.
    a_cmd_data = 8'd200; a_cmd_valid = 1'b1;
    cyc(1);
    a_cmd_valid = 1'b0; a_enable = 1'b0;
    chk("sim_ready_lo", a_cmd_ready, 0);
    cyc(14);
    chk("sim_tick_restart", a_frame_tick, 1);
    chk("sim_pos_hold", a_pos, 16700);
    cyc(1);
    chk("sim_off_pos", a_pos, 0);
    chk("sim_off_timer", a_timer_ena, 0);
    chk("sim_ready", a_cmd_ready, 1);
    chk("sim_busy", a_busy, 0);
    a_enable = 1'b1;
    cyc(1);
    chk("sim_reen_pos", a_pos, 21400);
    chk("sim_reen_timer", a_timer_ena, 1);

    // Reset during a ramp with a command pending.
    a_cmd_data = 8'd0; a_cmd_valid = 1'b1;
    cyc(1);
    a_cmd_valid = 1'b0;
    cyc(15);
    chk("rr_hold", a_pos, 21400);
    chk("rr_busy", a_busy, 1);
    cyc(16);
    chk("rr_step", a_pos, 21160);
    a_cmd_data = 8'd50; a_cmd_valid = 1'b1;
    cyc(1);
    a_cmd_valid = 1'b0;
    chk("rr_pend", a_cmd_ready, 0);
    a_rstn = 1'b0;
    cyc(1);
    chk("rr_pos", a_pos, 0);
    chk("rr_timer", a_timer_ena, 0);
    chk("rr_ready", a_cmd_ready, 1);
    chk("rr_busy0", a_busy, 0);
    chk("rr_tick", a_frame_tick, 0);
    a_rstn = 1'b1;
    cyc(1);
    chk("rr_reen_pos", a_pos, 18016);
    chk("rr_reen_timer", a_timer_ena, 1);

    // STEP=0 jump on b; clamp on c.
    b_cmd_data = 8'd0;   b_cmd_valid = 1'b1;
    c_cmd_data = 8'd255; c_cmd_valid = 1'b1;
    cyc(1);
    b_cmd_valid = 1'b0; c_cmd_valid = 1'b0;
    chk("b_off_acc", b_cmd_ready, 0);
    chk("c_off_acc", c_cmd_ready, 0);
    chk("b_off_busy", b_busy, 1);
    cyc(1);
    chk("b_off_xfer", b_cmd_ready, 1);
    chk("b_off_busy0", b_busy, 0);
    b_enable = 1'b1; c_enable = 1'b1;
    cyc(1);
    chk("b_run_pos", b_pos, 12000);
    chk("b_run_timer", b_timer_ena, 1);
    chk("c_clamp_pos", c_pos, 20000);
    b_cmd_data = 8'd255; b_cmd_valid = 1'b1;
    cyc(1);
    b_cmd_valid = 1'b0;
    cyc(14);
    chk("b_tick", b_frame_tick, 1);
    chk("b_tick_pos", b_pos, 12000);
    cyc(1);
    chk("b_xfer_pos", b_pos, 12000);
    chk("b_xfer_busy", b_busy, 1);
    cyc(16);
    chk("b_jump_pos", b_pos, 23985);
    chk("b_jump_busy", b_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
